// File: rtl/flag_mon_pkg.sv
// rtl/flag_mon_pkg.sv - shared state encoding and default constants for the flag sequence monitor
package flag_mon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S0   = 3'd1,
      ST_S1   = 3'd2,
      ST_S2   = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   localparam int          SEQ_W_DEF  = 8;
   localparam int          EDGE_W_DEF = 4;
   localparam logic [19:0] ID_NUM_DEF = 20'd65166;

endpackage

// File: rtl/rise_counter.sv
// rtl/rise_counter.sv - rising-edge detector feeding a wrapping counter with sync clear and enable
module rise_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         preset0,
   input  logic         en,
   input  logic         clr,
   input  logic         d,
   output logic [W-1:0] count
);

   logic         d_q;
   logic         d_d;
   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // History resets high so a level already asserted out of reset is not an edge.
   always_comb begin
      d_d     = d_q;
      count_d = count_q;
      if (en) begin
         d_d = d;
         if (d && !d_q) begin
            count_d = count_q + 1'b1;
         end
      end
      if (clr) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge preset0) begin
      if (!preset0) begin
         d_q     <= 1'b1;
         count_q <= '0;
      end else begin
         d_q     <= d_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/flag_sequence_monitor.sv
// rtl/flag_sequence_monitor.sv - detects the flag code sequence 00,01,11,10 and counts completions and op2 edges
module flag_sequence_monitor
   import flag_mon_pkg::*;
#(
   parameter logic [19:0] ID_NUM = ID_NUM_DEF,
   parameter int          SEQ_W  = SEQ_W_DEF,
   parameter int          EDGE_W = EDGE_W_DEF
) (
   input  logic              clk,
   input  logic              preset0,
   input  logic              en,
   input  logic              clr_cnt,
   input  logic              op0,
   input  logic              op1,
   input  logic              op2,
   output logic              match,
   output logic              busy,
   output logic [2:0]        state,
   output logic [SEQ_W-1:0]  seq_count,
   output logic [EDGE_W-1:0] edge_count,
   output logic [19:0]       id_num
);

   state_e           state_q;
   state_e           state_d;
   logic [SEQ_W-1:0] seq_q;
   logic [SEQ_W-1:0] seq_d;
   logic [1:0]       code;

   assign code = {op1, op0};

   always_ff @(posedge clk or negedge preset0) begin
      if (!preset0) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (en) begin
         case (state_q)
            ST_IDLE: state_d = (code == 2'b00) ? ST_S0 : ST_IDLE;
            ST_S0: begin
               case (code)
                  2'b00:   state_d = ST_S0;
                  2'b01:   state_d = ST_S1;
                  default: state_d = ST_IDLE;
               endcase
            end
            ST_S1: begin
               case (code)
                  2'b00:   state_d = ST_S0;
                  2'b01:   state_d = ST_S1;
                  2'b11:   state_d = ST_S2;
                  default: state_d = ST_IDLE;
               endcase
            end
            ST_S2: begin
               case (code)
                  2'b00:   state_d = ST_S0;
                  2'b11:   state_d = ST_S2;
                  2'b10:   state_d = ST_DONE;
                  default: state_d = ST_IDLE;
               endcase
            end
            ST_DONE: state_d = (code == 2'b00) ? ST_S0 : ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      match = (state_q == ST_DONE);
      busy  = (state_q != ST_IDLE);
   end

   // Clear is honoured even with en low and wins over a same-edge completion.
   always_comb begin
      seq_d = seq_q;
      if (clr_cnt) begin
         seq_d = '0;
      end else if (en && (state_d == ST_DONE) && (seq_q != {SEQ_W{1'b1}})) begin
         seq_d = seq_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge preset0) begin
      if (!preset0) begin
         seq_q <= '0;
      end else begin
         seq_q <= seq_d;
      end
   end

   rise_counter #(
      .W (EDGE_W)
   ) u_edge_cnt (
      .clk     (clk),
      .preset0 (preset0),
      .en      (en),
      .clr     (clr_cnt),
      .d       (op2),
      .count   (edge_count)
   );

   assign state     = state_q;
   assign seq_count = seq_q;
   assign id_num    = ID_NUM;

endmodule

// File: tb/tb_flag_sequence_monitor.sv
// tb/tb_flag_sequence_monitor.sv - directed self-checking bench for flag_sequence_monitor
module tb_flag_sequence_monitor;

   logic       clk;
   logic       preset0;
   logic       en;
   logic       clr_cnt;
   logic       op0;
   logic       op1;
   logic       op2;
   logic       match;
   logic       busy;
   logic [2:0] state;
   logic [7:0] seq_count;
   logic [3:0] edge_count;
   logic [19:0] id_num;

   int n_checks = 0;
   int n_fail   = 0;

   flag_sequence_monitor dut (
      .clk        (clk),
      .preset0    (preset0),
      .en         (en),
      .clr_cnt    (clr_cnt),
      .op0        (op0),
      .op1        (op1),
      .op2        (op2),
      .match      (match),
      .busy       (busy),
      .state      (state),
      .seq_count  (seq_count),
      .edge_count (edge_count),
      .id_num     (id_num)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic [1:0] c, input logic o2, input logic e, input logic clr);
      op1     = c[1];
      op0     = c[0];
      op2     = o2;
      en      = e;
      clr_cnt = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      preset0 = 1'b0;
      en = 1'b0; clr_cnt = 1'b0; op0 = 1'b1; op1 = 1'b1; op2 = 1'b0;
      #23;
      n_checks++;
      if (state !== 3'd0 || busy !== 1'b0 || match !== 1'b0) begin
         $display("FAIL reset_fsm: state=%0d busy=%b match=%b, expected 0/0/0", state, busy, match); n_fail++;
      end
      n_checks++;
      if (seq_count !== 8'd0 || edge_count !== 4'd0) begin
         $display("FAIL reset_cnt: seq=%0d edge=%0d, expected 0/0", seq_count, edge_count); n_fail++;
      end
      n_checks++;
      if (id_num !== 20'd65166) begin
         $display("FAIL reset_id: id_num=%0d, expected 65166", id_num); n_fail++;
      end
      @(posedge clk); #1;
      preset0 = 1'b1;
   endtask

   task automatic test_full_sequence;
      logic [1:0] codes [5];
      logic [2:0] exp_st [5];
      logic       exp_m [5];
      codes  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
      exp_st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
      exp_m  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         step(codes[i], 1'b0, 1'b1, 1'b0);
         n_checks++;
         if (state !== exp_st[i] || match !== exp_m[i] || busy !== 1'b1) begin
            $display("FAIL full_seq step %0d: state=%0d match=%b busy=%b, expected %0d/%b/1",
                     i, state, match, busy, exp_st[i], exp_m[i]); n_fail++;
         end
      end
      n_checks++;
      if (seq_count !== 8'd1) begin
         $display("FAIL full_seq_count: seq=%0d, expected 1", seq_count); n_fail++;
      end
   endtask

   task automatic test_broken_sequence;
      logic [1:0] codes [3];
      logic [2:0] exp_st [3];
      codes  = '{2'b00, 2'b01, 2'b10};
      exp_st = '{3'd1, 3'd2, 3'd0};
      for (int i = 0; i < 3; i++) begin
         step(codes[i], 1'b0, 1'b1, 1'b0);
         n_checks++;
         if (state !== exp_st[i] || match !== 1'b0) begin
            $display("FAIL broken_seq step %0d: state=%0d match=%b, expected %0d/0",
                     i, state, match, exp_st[i]); n_fail++;
         end
      end
      n_checks++;
      if (seq_count !== 8'd1 || busy !== 1'b0) begin
         $display("FAIL broken_seq_end: seq=%0d busy=%b, expected 1/0", seq_count, busy); n_fail++;
      end
   endtask

   task automatic test_enable_hold;
      step(2'b00, 1'b0, 1'b1, 1'b0);
      step(2'b01, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(2'b11, 1'b1, 1'b0, 1'b0);
         n_checks++;
         if (state !== 3'd2 || seq_count !== 8'd1 || edge_count !== 4'd0) begin
            $display("FAIL en_hold cycle %0d: state=%0d seq=%0d edge=%0d, expected 2/1/0",
                     i, state, seq_count, edge_count); n_fail++;
         end
      end
      step(2'b11, 1'b0, 1'b1, 1'b0);
      step(2'b10, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (state !== 3'd4 || match !== 1'b1 || seq_count !== 8'd2) begin
         $display("FAIL en_resume: state=%0d match=%b seq=%0d, expected 4/1/2", state, match, seq_count); n_fail++;
      end
      step(2'b01, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (state !== 3'd0 || match !== 1'b0) begin
         $display("FAIL done_one_cycle: state=%0d match=%b, expected 0/0", state, match); n_fail++;
      end
   endtask

   task automatic test_edge_count;
      for (int i = 0; i < 17; i++) begin
         step(2'b11, 1'b0, 1'b1, 1'b0);
         step(2'b11, 1'b1, 1'b1, 1'b0);
      end
      n_checks++;
      if (edge_count !== 4'd1) begin
         $display("FAIL edge_wrap: edge=%0d, expected 1", edge_count); n_fail++;
      end
      step(2'b11, 1'b0, 1'b1, 1'b0);
      step(2'b11, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if (edge_count !== 4'd0 || seq_count !== 8'd0) begin
         $display("FAIL edge_clr: edge=%0d seq=%0d, expected 0/0", edge_count, seq_count); n_fail++;
      end
      step(2'b11, 1'b0, 1'b1, 1'b0);
      step(2'b11, 1'b1, 1'b1, 1'b0);
      step(2'b11, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (edge_count !== 4'd0) begin
         $display("FAIL edge_clr_disabled: edge=%0d, expected 0", edge_count); n_fail++;
      end
   endtask

   task automatic test_saturation;
      logic [1:0] codes [4];
      codes = '{2'b00, 2'b01, 2'b11, 2'b10};
      for (int s = 0; s < 256; s++) begin
         for (int i = 0; i < 4; i++) step(codes[i], 1'b0, 1'b1, 1'b0);
      end
      n_checks++;
      if (seq_count !== 8'd255) begin
         $display("FAIL seq_sat: seq=%0d, expected 255", seq_count); n_fail++;
      end
      for (int i = 0; i < 4; i++) step(codes[i], 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (seq_count !== 8'd255 || match !== 1'b1) begin
         $display("FAIL seq_sat_hold: seq=%0d match=%b, expected 255/1", seq_count, match); n_fail++;
      end
   endtask

   task automatic test_async_reset;
      step(2'b00, 1'b0, 1'b1, 1'b0);
      step(2'b01, 1'b1, 1'b1, 1'b0);
      step(2'b11, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (state !== 3'd3 || edge_count === 4'd0) begin
         $display("FAIL pre_reset: state=%0d edge=%0d, expected 3/nonzero", state, edge_count); n_fail++;
      end
      #2;
      preset0 = 1'b0;
      #1;
      n_checks++;
      if (state !== 3'd0 || match !== 1'b0 || busy !== 1'b0 || seq_count !== 8'd0 || edge_count !== 4'd0) begin
         $display("FAIL async_reset: state=%0d match=%b busy=%b seq=%0d edge=%0d, expected all 0",
                  state, match, busy, seq_count, edge_count); n_fail++;
      end
      op1 = 1'b1; op0 = 1'b0;
      #24;
      preset0 = 1'b1;
      n_checks++;
      if (match !== 1'b0 || seq_count !== 8'd0 || id_num !== 20'd65166) begin
         $display("FAIL reset_abort: match=%b seq=%0d id=%0d, expected 0/0/65166", match, seq_count, id_num); n_fail++;
      end
      step(2'b00, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (state !== 3'd1 || edge_count !== 4'd0) begin
         $display("FAIL post_reset_edge: state=%0d edge=%0d, expected 1/0", state, edge_count); n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_full_sequence();
      test_broken_sequence();
      test_enable_hold();
      test_edge_count();
      test_saturation();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/flag_sequence_monitor.md
FLAG_SEQUENCE_MONITOR -- requirements
Module: flag_sequence_monitor

Interface
REQ-001 Parameter: ID_NUM, default 20'd65166, constant identifier driven on id_num.
REQ-002 Parameter: SEQ_W, default 8, width of seq_count.
REQ-003 Parameter: EDGE_W, default 4, width of edge_count.
REQ-004 Reset and clock SHALL be exactly: reset preset0, asynchronous, active-low; clock clk.
REQ-005 clk  input  1  rising-edge clock, shared with the upstream flag-register stage.
REQ-006 preset0  input  1  asynchronous active-low reset.
REQ-007 en  input  1  sample enable; low = all state held.
REQ-008 clr_cnt  input  1  synchronous clear of both counters.
REQ-009 op0  input  1  upstream flag 0, synchronous to clk.
REQ-010 op1  input  1  upstream flag 1, synchronous to clk.
REQ-011 op2  input  1  upstream NAND flag, synchronous to clk.
REQ-012 match  output  1  one-cycle pulse when a full sequence completes.
REQ-013 busy  output  1  high whenever FSM is not IDLE.
REQ-014 state  output  3  current FSM state code.
REQ-015 seq_count  output  SEQ_W  completed-sequence count, saturating.
REQ-016 edge_count  output  EDGE_W  op2 rising-edge count, wrapping.
REQ-017 id_num  output  20  constant ID_NUM, independent of reset and clock.

Function
REQ-018 Code c = {op1,op0}, sampled on each rising clk when en=1; when en=0, FSM, counters and op2 history SHALL hold.
REQ-019 FSM states (codes): IDLE=0, S0=1, S1=2, S2=3, DONE=4; codes 5-7 SHALL return to IDLE on next enabled edge.
REQ-020 IDLE: c=00 -> S0; else stay IDLE.
REQ-021 S0: c=01 -> S1; c=00 -> stay S0; else -> IDLE.
REQ-022 S1: c=11 -> S2; c=01 -> stay S1; c=00 -> S0; c=10 -> IDLE.
REQ-023 S2: c=10 -> DONE; c=11 -> stay S2; c=00 -> S0; c=01 -> IDLE.
REQ-024 DONE: c=00 -> S0; else -> IDLE; DONE SHALL last exactly one enabled cycle.
REQ-025 match SHALL be Moore (state==DONE): high the cycle after the edge sampling c=10 in S2, one-cycle latency, no combinational path from inputs.
REQ-026 busy = (state != IDLE), registered-state derived.
REQ-027 seq_count SHALL increment by 1 on each edge entering DONE; saturates at 2^SEQ_W-1 (255) and holds.
REQ-028 edge_count SHALL increment by 1 on each enabled edge where op2=1 and stored op2_q=0; wraps 15 -> 0.
REQ-029 op2_q SHALL update to op2 on every enabled edge.
REQ-030 clr_cnt=1 on an enabled or disabled edge SHALL zero both counters; clear takes priority over a simultaneous increment; FSM unaffected.
REQ-031 Counters SHALL ignore en=0 for clr_cnt only; increments require en=1.

Reset
REQ-032 preset0=0 SHALL immediately force state=IDLE, match=0, busy=0, seq_count=0, edge_count=0, op2_q=1.
REQ-033 Reset asserted mid-sequence (any state) SHALL abort it with no match pulse and no count increment.
REQ-034 First enabled edge after preset0 rises SHALL be evaluated normally; op2 already high SHALL not count (op2_q=1).

Structure
REQ-035 Shared package flag_mon_pkg SHALL hold state encoding, default SEQ_W/EDGE_W and ID_NUM constants.
REQ-036 One sub-module rise_counter (rising-edge detect + wrapping counter + sync clear + enable) SHALL implement edge_count; FSM and seq_count in the top.

Verification
REQ-037 Reset then c sequence 00,01,11,10,00 with en=1 -> match high only in cycle after 10 sampled, seq_count=1, state back to S0.
REQ-038 Sequence 00,01,10 -> state IDLE after 10, no match, seq_count unchanged.
REQ-039 Hold en=0 for 3 cycles mid-sequence (in S1) then resume 11,10 -> match still produced, seq_count +1; no change while en=0.
REQ-040 op2 toggling 0/1 for 17 rising edges -> edge_count=1 (wrap); clr_cnt pulsed coincident with an op2 rising edge -> edge_count=0.
REQ-041 Preload 256 complete sequences -> seq_count=255 and holds on 257th.
REQ-042 preset0 pulsed low 25 ns during S2 -> state=IDLE, counters 0 asynchronously, no match; id_num=65166 throughout.
